// File: rtl/flash_read_fsm_pkg.sv
// Shared types and constants for the flash sample-fetch responder.
package flash_read_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_VALID = 2'd2,
    DONE       = 2'd3
  } state_e;

  localparam logic [3:0] FLASH_BYTEENABLE = 4'hF;
  localparam logic [5:0] FLASH_BURSTCOUNT = 6'd1;

endpackage

// File: rtl/flash_read_fsm_if.sv
// Avalon-MM read-side bundle between the responder (master) and the flash controller (slave).
interface flash_read_fsm_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);

  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic [5:0]        flash_mem_burstcount;
  logic              flash_mem_waitrequest;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    output flash_mem_burstcount,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    input  flash_mem_burstcount,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );

endinterface

// File: rtl/flash_read_fsm_timeout_counter.sv
// Cycle counter that flags when an outstanding read has run for TIMEOUT_CYCLES.
module flash_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;

  // Holds at the limit so the counter can never wrap back below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/flash_read_fsm.sv
// Flash-side responder: turns one start_read request into a single Avalon-MM read.
module flash_read_fsm
  import flash_read_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk_50M,
  input  logic                reset_n,
  input  logic                start_read,
  input  logic [ADDR_W-1:0]   req_address,
  output logic                read_done,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_error,
  flash_read_fsm_if.master    mem,
  output logic [1:0]          state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_q, rd_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cnt_clear, cnt_en, expired;

  flash_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk_50M),
    .rst_n  (reset_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expired(expired)
  );

  // Timeout wins over a coincident readdatavalid; a timed-out read returns zero.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_read) begin
          addr_d    = req_address;
          cnt_clear = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_en = 1'b1;
        if (expired) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (!mem.flash_mem_waitrequest) begin
          state_d = WAIT_VALID;
        end
      end
      WAIT_VALID: begin
        cnt_en = 1'b1;
        if (expired) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mem.flash_mem_readdatavalid) begin
          data_d  = mem.flash_mem_readdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rd_d   = (state_d == ISSUE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem.flash_mem_read       = rd_q;
  assign mem.flash_mem_address    = addr_q;
  assign mem.flash_mem_byteenable = FLASH_BYTEENABLE;
  assign mem.flash_mem_burstcount = FLASH_BURSTCOUNT;
  assign read_done                = done_q;
  assign read_error               = err_q;
  assign read_data                = data_q;
  assign state                    = state_q;

endmodule

// File: tb/tb_flash_read_fsm.sv
// Directed bench for flash_read_fsm: reset, basic, stall, back-to-back, timeout, stray data, reset mid-read.
module tb_flash_read_fsm;

  localparam int ADDR_W         = 23;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 8;

  logic              clk_50M     = 1'b0;
  logic              reset_n     = 1'b0;
  logic              start_read  = 1'b0;
  logic [ADDR_W-1:0] req_address = '0;
  logic              read_done;
  logic              read_error;
  logic [DATA_W-1:0] read_data;
  logic [1:0]        state;

  int checks   = 0;
  int failures = 0;

  flash_read_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  flash_read_fsm #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_50M    (clk_50M),
    .reset_n    (reset_n),
    .start_read (start_read),
    .req_address(req_address),
    .read_done  (read_done),
    .read_data  (read_data),
    .read_error (read_error),
    .mem        (mem_if),
    .state      (state)
  );

  always #10 clk_50M = ~clk_50M;

  // Advance one cycle; outputs are then observed and next inputs driven 1ns after the edge.
  task automatic step;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (mem_if.flash_mem_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", mem_if.flash_mem_read); end
    checks++; if (read_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", read_done); end
    checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", read_error); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", read_data); end
    checks++; if (mem_if.flash_mem_address !== 23'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_if.flash_mem_address); end
    checks++; if (mem_if.flash_mem_byteenable !== 4'hF) begin failures++; $display("FAIL byteenable got=%h exp=f", mem_if.flash_mem_byteenable); end
    checks++; if (mem_if.flash_mem_burstcount !== 6'd1) begin failures++; $display("FAIL burstcount got=%0d exp=1", mem_if.flash_mem_burstcount); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic;
    start_read  = 1'b1;
    req_address = 23'h000010;
    mem_if.flash_mem_waitrequest = 1'b0;
    step();  // cycle 1
    start_read = 1'b0;
    checks++; if (mem_if.flash_mem_read !== 1'b1) begin failures++; $display("FAIL basic_read_c1 got=%b exp=1", mem_if.flash_mem_read); end
    checks++; if (mem_if.flash_mem_address !== 23'h000010) begin failures++; $display("FAIL basic_addr got=%h exp=000010", mem_if.flash_mem_address); end
    checks++; if (read_done !== 1'b0) begin failures++; $display("FAIL basic_done_c1 got=%b exp=0", read_done); end
    step();  // cycle 2
    checks++; if (mem_if.flash_mem_read !== 1'b0) begin failures++; $display("FAIL basic_read_c2 got=%b exp=0", mem_if.flash_mem_read); end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL basic_state_c2 got=%0d exp=2", state); end
    mem_if.flash_mem_readdatavalid = 1'b1;
    mem_if.flash_mem_readdata      = 32'hDEADBEEF;
    step();  // cycle 3
    mem_if.flash_mem_readdatavalid = 1'b0;
    mem_if.flash_mem_readdata      = 32'h0;
    checks++; if (read_done !== 1'b1) begin failures++; $display("FAIL basic_done_c3 got=%b exp=1", read_done); end
    checks++; if (read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got=%h exp=deadbeef", read_data); end
    checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL basic_error got=%b exp=0", read_error); end
    step();  // cycle 4
    checks++; if (read_done !== 1'b0) begin failures++; $display("FAIL basic_done_c4 got=%b exp=0", read_done); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL basic_state_c4 got=%0d exp=0", state); end
  endtask

  task automatic test_stall;
    logic [DATA_W-1:0] prev;
    int rd_cycles  = 0;
    int done_cycle = -1;
    int done_cnt   = 0;
    bit addr_ok    = 1'b1;
    prev        = read_data;
    start_read  = 1'b1;
    req_address = 23'h1234AB;
    mem_if.flash_mem_waitrequest = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin
        start_read  = 1'b0;
        req_address = 23'h7FFFFF;
      end
      if (mem_if.flash_mem_read === 1'b1) begin
        rd_cycles++;
        if (mem_if.flash_mem_address !== 23'h1234AB) addr_ok = 1'b0;
      end
      if (read_done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (k == 4) begin
        checks++; if (read_data !== prev) begin failures++; $display("FAIL stall_stray_issue got=%h exp=%h", read_data, prev); end
      end
      mem_if.flash_mem_waitrequest   = (k <= 5);
      mem_if.flash_mem_readdatavalid = (k == 3) || (k == 7);
      mem_if.flash_mem_readdata      = (k == 3) ? 32'h99999999 : (k == 7) ? 32'hCAFEF00D : 32'h0;
    end
    mem_if.flash_mem_waitrequest = 1'b0;
    checks++; if (rd_cycles != 6) begin failures++; $display("FAIL stall_read_cycles got=%0d exp=6", rd_cycles); end
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL stall_addr_const got=%b exp=1", addr_ok); end
    checks++; if (done_cycle != 8) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=8", done_cycle); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt); end
    checks++; if (read_data !== 32'hCAFEF00D) begin failures++; $display("FAIL stall_data got=%h exp=cafef00d", read_data); end
  endtask

  task automatic test_back_to_back;
    int done_cnt = 0;
    start_read  = 1'b1;
    req_address = 23'h0;
    mem_if.flash_mem_waitrequest = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 4 == 1) begin
        checks++;
        if (mem_if.flash_mem_read !== 1'b1 || mem_if.flash_mem_address !== ADDR_W'((k - 1) / 4)) begin
          failures++;
          $display("FAIL b2b_issue k=%0d got read=%b addr=%h exp read=1 addr=%h", k, mem_if.flash_mem_read, mem_if.flash_mem_address, ADDR_W'((k - 1) / 4));
        end
      end
      if (k % 4 == 3) begin
        checks++;
        if (read_done !== 1'b1 || read_data !== (32'hA0000000 + 32'((k - 3) / 4))) begin
          failures++;
          $display("FAIL b2b_done k=%0d got done=%b data=%h exp done=1 data=%h", k, read_done, read_data, 32'hA0000000 + 32'((k - 3) / 4));
        end
      end
      if (read_done === 1'b1) done_cnt++;
      req_address = (k % 4 == 0) ? ADDR_W'(k / 4) : 23'h055555;
      mem_if.flash_mem_readdatavalid = (k % 4 == 2);
      mem_if.flash_mem_readdata      = (k % 4 == 2) ? 32'hA0000000 + 32'((k - 2) / 4) : 32'h0;
      if (k == 11) start_read = 1'b0;
    end
    checks++; if (done_cnt != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_cnt); end
  endtask

  task automatic test_timeout;
    bit exp_done;
    start_read  = 1'b1;
    req_address = 23'h000ABC;
    mem_if.flash_mem_waitrequest   = 1'b0;
    mem_if.flash_mem_readdatavalid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) start_read = 1'b0;
      exp_done = (k == TIMEOUT_CYCLES + 2);
      checks++; if (read_done !== exp_done) begin failures++; $display("FAIL timeout_done k=%0d got=%b exp=%b", k, read_done, exp_done); end
      checks++; if (read_error !== exp_done) begin failures++; $display("FAIL timeout_error k=%0d got=%b exp=%b", k, read_error, exp_done); end
      if (k == TIMEOUT_CYCLES + 2) begin
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL timeout_data got=%h exp=0", read_data); end
      end
      if (k == 11) begin
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL timeout_state got=%0d exp=0", state); end
      end
      // readdatavalid lands on the expiry cycle: the timeout must still win
      mem_if.flash_mem_readdatavalid = (k == TIMEOUT_CYCLES + 1);
      mem_if.flash_mem_readdata      = (k == TIMEOUT_CYCLES + 1) ? 32'h5A5A5A5A : 32'h0;
    end
  endtask

  task automatic test_stray_data;
    start_read  = 1'b1;
    req_address = 23'h000020;
    step();  // cycle 1
    start_read = 1'b0;
    step();  // cycle 2
    mem_if.flash_mem_readdatavalid = 1'b1;
    mem_if.flash_mem_readdata      = 32'h600DCAFE;
    step();  // cycle 3
    mem_if.flash_mem_readdatavalid = 1'b0;
    checks++; if (read_done !== 1'b1 || read_data !== 32'h600DCAFE) begin failures++; $display("FAIL stray_setup got done=%b data=%h exp done=1 data=600dcafe", read_done, read_data); end
    step();  // idle
    mem_if.flash_mem_readdatavalid = 1'b1;
    mem_if.flash_mem_readdata      = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (read_done !== 1'b0) begin failures++; $display("FAIL stray_done k=%0d got=%b exp=0", k, read_done); end
      checks++; if (read_data !== 32'h600DCAFE) begin failures++; $display("FAIL stray_data k=%0d got=%h exp=600dcafe", k, read_data); end
    end
    mem_if.flash_mem_readdatavalid = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    start_read  = 1'b1;
    req_address = 23'h000040;
    step();  // cycle 1
    start_read = 1'b0;
    step();  // cycle 2
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rstmid_pre_state got=%0d exp=2", state); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", state); end
    checks++; if (mem_if.flash_mem_read !== 1'b0) begin failures++; $display("FAIL rstmid_read got=%b exp=0", mem_if.flash_mem_read); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", read_data); end
    checks++; if (mem_if.flash_mem_address !== 23'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", mem_if.flash_mem_address); end
    step();
    reset_n = 1'b1;
    mem_if.flash_mem_readdatavalid = 1'b1;
    mem_if.flash_mem_readdata      = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (read_done !== 1'b0) begin failures++; $display("FAIL rstmid_done k=%0d got=%b exp=0", k, read_done); end
      checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL rstmid_after_data k=%0d got=%h exp=0", k, read_data); end
    end
    mem_if.flash_mem_readdatavalid = 1'b0;
  endtask

  initial begin
    mem_if.flash_mem_waitrequest   = 1'b0;
    mem_if.flash_mem_readdata      = 32'h0;
    mem_if.flash_mem_readdatavalid = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_stray_data();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=bench_complete");
    $fatal(1, "bench did not complete");
  end

endmodule
